// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl_fsm
//  Purpose  : Multicycle MIPS control unit (Moore main decoder + ALU decoder)
//             with a retired-instruction counter.
//  Revision : 1.0
// ============================================================================
module mc_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    output logic             PCWrite,
    output logic             Branch,
    output logic [1:0]       PCSrc,
    output logic [2:0]       ALUControl,
    output logic [1:0]       ALUSrcB,
    output logic             ALUSrcA,
    output logic             RegWrite,
    output logic             lorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    localparam logic [5:0] c_OP_R    = 6'b000000;
    localparam logic [5:0] c_OP_J    = 6'b000010;
    localparam logic [5:0] c_OP_BEQ  = 6'b000100;
    localparam logic [5:0] c_OP_ADDI = 6'b001000;
    localparam logic [5:0] c_OP_LW   = 6'b100011;
    localparam logic [5:0] c_OP_SW   = 6'b101011;

    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

    logic [3:0]       r_state;
    logic [CNT_W-1:0] r_retired;
    logic [1:0]       w_alu_op;
    logic             w_retire;

    // States that complete an instruction; leaving one of them retires it.
    assign w_retire = (r_state == S_MEMWB)  || (r_state == S_MEMWR)  ||
                      (r_state == S_ALUWB)  || (r_state == S_BRANCH) ||
                      (r_state == S_ADDIWB) || (r_state == S_JUMP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            if (w_retire)
                r_retired <= r_retired + CNT_W'(1);
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    case (Op)
                        c_OP_LW, c_OP_SW: r_state <= S_MEMADR;
                        c_OP_R:           r_state <= S_EXEC;
                        c_OP_BEQ:         r_state <= S_BRANCH;
                        c_OP_ADDI:        r_state <= S_ADDIEX;
                        c_OP_J:           r_state <= S_JUMP;
                        default:          r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR: r_state <= (Op == c_OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  r_state <= S_MEMWB;
                S_EXEC:   r_state <= S_ALUWB;
                S_ADDIEX: r_state <= S_ADDIWB;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // ALUOp is left at add (00) in states that do not use the ALU result.
    always_comb begin
        PCWrite  = 1'b0;
        Branch   = 1'b0;
        PCSrc    = 2'b00;
        ALUSrcB  = 2'b00;
        ALUSrcA  = 1'b0;
        RegWrite = 1'b0;
        lorD     = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        w_alu_op = c_ALUOP_ADD;
        case (r_state)
            S_FETCH:  begin IRWrite = 1'b1; PCWrite = 1'b1; ALUSrcB = 2'b01; end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
            S_MEMRD:  lorD = 1'b1;
            S_MEMWB:  begin RegWrite = 1'b1; MemtoReg = 1'b1; end
            S_MEMWR:  begin lorD = 1'b1; MemWrite = 1'b1; end
            S_EXEC:   begin ALUSrcA = 1'b1; w_alu_op = c_ALUOP_FUNCT; end
            S_ALUWB:  begin RegWrite = 1'b1; RegDst = 1'b1; end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                w_alu_op = c_ALUOP_SUB;
                Branch   = 1'b1;
                PCSrc    = 2'b01;
            end
            S_ADDIEX: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP:   begin PCWrite = 1'b1; PCSrc = 2'b10; end
            default:  ;
        endcase
    end

    always_comb begin
        ALUControl = 3'b010;
        case (w_alu_op)
            c_ALUOP_SUB: ALUControl = 3'b110;
            c_ALUOP_FUNCT: begin
                case (Funct)
                    6'b100010: ALUControl = 3'b110;
                    6'b100100: ALUControl = 3'b000;
                    6'b100101: ALUControl = 3'b001;
                    6'b101010: ALUControl = 3'b111;
                    default:   ALUControl = 3'b010;
                endcase
            end
            default: ALUControl = 3'b010;
        endcase
    end

    assign state_o = r_state;
    assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_ctrl_fsm
//  Purpose  : Scoreboard bench for mc_ctrl_fsm (4-bit retired counter).
//  Revision : 1.0
// ============================================================================
module tb_mc_ctrl_fsm;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       Op, Funct;
    logic             PCWrite, Branch, ALUSrcA, RegWrite, lorD, MemWrite;
    logic             IRWrite, RegDst, MemtoReg;
    logic [1:0]       PCSrc, ALUSrcB;
    logic [2:0]       ALUControl;
    logic [3:0]       state_o;
    logic [CNT_W-1:0] retired;
    logic [15:0]      w_ctl;

    mc_ctrl_fsm #(.CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct),
        .PCWrite(PCWrite), .Branch(Branch), .PCSrc(PCSrc),
        .ALUControl(ALUControl), .ALUSrcB(ALUSrcB), .ALUSrcA(ALUSrcA),
        .RegWrite(RegWrite), .lorD(lorD), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .state_o(state_o), .retired(retired)
    );

    always #5 clk = ~clk;

    assign w_ctl = {PCWrite, Branch, PCSrc, ALUControl, ALUSrcB, ALUSrcA,
                    RegWrite, lorD, MemWrite, IRWrite, RegDst, MemtoReg};

    typedef struct {
        string      tag;
        logic [3:0] st;
        logic [15:0] ctl;
        logic [3:0] ret;
    } exp_t;

    exp_t       r_q[$];
    int         r_checks = 0;
    int         r_pass   = 0;
    logic [3:0] r_exp_ret = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_checks++;
        if (got === exp) r_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [2:0] exp_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected control word per state, in w_ctl bit order.
    function automatic logic [15:0] exp_ctl(input logic [3:0] s, input logic [5:0] f);
        logic pcw, br, srca, rw, iord, mw, irw, rdst, m2r;
        logic [1:0] pcs, srcb;
        logic [2:0] aluc;
        {pcw, br, srca, rw, iord, mw, irw, rdst, m2r} = '0;
        pcs = 2'b00; srcb = 2'b00; aluc = 3'b010;
        case (s)
            4'd0:  begin pcw = 1; irw = 1; srcb = 2'b01; end
            4'd1:  srcb = 2'b11;
            4'd2:  begin srca = 1; srcb = 2'b10; end
            4'd3:  iord = 1;
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin iord = 1; mw = 1; end
            4'd6:  begin srca = 1; aluc = exp_alu(f); end
            4'd7:  begin rw = 1; rdst = 1; end
            4'd8:  begin srca = 1; aluc = 3'b110; br = 1; pcs = 2'b01; end
            4'd9:  begin srca = 1; srcb = 2'b10; end
            4'd10: rw = 1;
            4'd11: begin pcw = 1; pcs = 2'b10; end
            default: ;
        endcase
        return {pcw, br, pcs, aluc, srcb, srca, rw, iord, mw, irw, rdst, m2r};
    endfunction

    // Drives one instruction; path holds the expected state sequence, first state in the low nibble.
    task automatic play(input string tag, input logic [5:0] op, input logic [5:0] f,
                        input int len, input logic [23:0] path, input bit retires);
        exp_t e;
        Op = op;
        Funct = f;
        for (int i = 0; i < len; i++) begin
            e.tag = $sformatf("%s_c%0d", tag, i);
            e.st  = path[4*i +: 4];
            e.ctl = exp_ctl(path[4*i +: 4], f);
            e.ret = r_exp_ret;
            r_q.push_back(e);
        end
        for (int i = 0; i < len; i++) begin
            e = r_q.pop_front();
            check({e.tag, "_state"}, 32'(state_o), 32'(e.st));
            check({e.tag, "_ctl"},   32'(w_ctl),   32'(e.ctl));
            check({e.tag, "_ret"},   32'(retired), 32'(e.ret));
            @(negedge clk);
        end
        if (retires) r_exp_ret = r_exp_ret + 4'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        r_exp_ret = '0;
    endtask

    logic [5:0] r_fn[6];

    initial begin
        rst = 1'b1; Op = 6'd0; Funct = 6'd0;
        @(negedge clk);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_ctl",   32'(w_ctl),   32'(exp_ctl(4'd0, 6'd0)));
        check("rst_ret",   32'(retired), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        play("lw", 6'b100011, 6'd0, 5, 24'h043210, 1'b1);

        // Asynchronous reset in the middle of EXEC abandons the instruction.
        play("sub_pre", 6'b000000, 6'b100010, 2, 24'h000010, 1'b0);
        check("pre_rst_state", 32'(state_o), 32'd6);
        #2 rst = 1'b1;
        #1;
        check("async_rst_state", 32'(state_o), 32'd0);
        check("async_rst_ret",   32'(retired), 32'd0);
        check("async_rst_ctl",   32'(w_ctl),   32'(exp_ctl(4'd0, 6'd0)));
        @(negedge clk);
        rst = 1'b0;
        r_exp_ret = '0;
        @(posedge clk);
        #1 check("post_rst_decode", 32'(state_o), 32'd1);
        @(negedge clk);
        play("sub_tail", 6'b000000, 6'b100010, 3, 24'h000761, 1'b1);

        r_fn = '{6'b101010, 6'b100000, 6'b100100, 6'b100101, 6'b000000, 6'b100010};
        foreach (r_fn[k])
            play($sformatf("rtype%0d", k), 6'b000000, r_fn[k], 4, 24'h007610, 1'b1);

        play("beq",     6'b000100, 6'd0, 3, 24'h000810, 1'b1);
        play("illegal", 6'b111111, 6'd0, 2, 24'h000010, 1'b0);
        play("j",       6'b000010, 6'd0, 3, 24'h000B10, 1'b1);
        play("addi",    6'b001000, 6'd0, 4, 24'h00A910, 1'b1);

        do_reset();
        for (int n = 0; n < 16; n++)
            play($sformatf("sw%0d", n), 6'b101011, 6'd0, 4, 24'h005210, 1'b1);
        check("sw_wrap_ret", 32'(retired), 32'd0);
        check("sw_wrap_state", 32'(state_o), 32'd0);
        check("queue_empty", 32'(r_q.size()), 32'd0);

        $display("%0d/%0d checks passed", r_pass, r_checks);
        $finish;
    end

endmodule
`default_nettype wire
